// File: rtl/pc_source_ctrl.sv
// PC source / exception sequencing FSM: fetch, decode, control transfers, execution watchdog and exception entry.
// Optional overflow exception enabled by defining PC_SOURCE_CTRL_OVF_EXC_EN.
module pc_source_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    input  logic       illegal_op,
    input  logic       exec_done,
    output logic [1:0] PcSourceControl,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       EPCWrite,
    output logic       link_write,
    output logic       alu_pc_minus4,
    output logic       exc_vec_sel,
    output logic [1:0] exc_cause,
    output logic       exec_start
);

    typedef enum logic [3:0] {
        ST_RST,
        ST_FETCH,
        ST_DECODE,
        ST_WAIT_EXEC,
        ST_BRANCH,
        ST_JUMP,
        ST_JR,
        ST_RTE,
        ST_EXC_SAVE,
        ST_EXC_VEC
    } state_t;

    localparam logic [1:0] SEL_ALU    = 2'b00;
    localparam logic [1:0] SEL_JTGT   = 2'b01;
    localparam logic [1:0] SEL_ALUOUT = 2'b10;
    localparam logic [1:0] SEL_EPC    = 2'b11;

    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b00;
    localparam logic [1:0] CAUSE_OVERFLOW = 2'b01;
    localparam logic [1:0] CAUSE_WATCHDOG = 2'b10;

    state_t     state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic [1:0] cause_reg, cause_next;
    logic       ovf_exc;

`ifdef PC_SOURCE_CTRL_OVF_EXC_EN
    assign ovf_exc = overflow;
`else
    logic unused_overflow;
    assign unused_overflow = overflow;
    assign ovf_exc         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_RST;
            cnt_reg   <= 8'd0;
            cause_reg <= CAUSE_ILLEGAL;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            cause_reg <= cause_next;
        end
    end

    // The cause register is loaded on the edge entering EXC_SAVE so it is already visible there.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cause_next = cause_reg;
        case (state_reg)
            ST_RST:    state_next = ST_FETCH;
            ST_FETCH:  state_next = ST_DECODE;
            ST_DECODE: begin
                if (illegal_op) begin
                    state_next = ST_EXC_SAVE;
                    cause_next = CAUSE_ILLEGAL;
                end else if (opcode == 6'h02 || opcode == 6'h03) begin
                    state_next = ST_JUMP;
                end else if (opcode == 6'h04 || opcode == 6'h05) begin
                    state_next = ST_BRANCH;
                end else if (opcode == 6'h00 && funct == 6'h08) begin
                    state_next = ST_JR;
                end else if (opcode == 6'h00 && funct == 6'h13) begin
                    state_next = ST_RTE;
                end else begin
                    state_next = ST_WAIT_EXEC;
                    cnt_next   = 8'd0;
                end
            end
            ST_WAIT_EXEC: begin
                cnt_next = cnt_reg + 8'd1;
                // exec_done has priority over the watchdog expiring in the same cycle.
                if (exec_done) begin
                    if (ovf_exc) begin
                        state_next = ST_EXC_SAVE;
                        cause_next = CAUSE_OVERFLOW;
                    end else begin
                        state_next = ST_FETCH;
                    end
                end else if (cnt_reg == 8'd254) begin
                    state_next = ST_EXC_SAVE;
                    cause_next = CAUSE_WATCHDOG;
                end
            end
            ST_BRANCH:   state_next = ST_FETCH;
            ST_JUMP:     state_next = ST_FETCH;
            ST_JR:       state_next = ST_FETCH;
            ST_RTE:      state_next = ST_FETCH;
            ST_EXC_SAVE: state_next = ST_EXC_VEC;
            ST_EXC_VEC:  state_next = ST_FETCH;
            default:     state_next = ST_RST;
        endcase
    end

    always_comb begin
        PcSourceControl = SEL_ALU;
        PCWrite         = 1'b0;
        IRWrite         = 1'b0;
        EPCWrite        = 1'b0;
        link_write      = 1'b0;
        alu_pc_minus4   = 1'b0;
        exc_vec_sel     = 1'b0;
        exec_start      = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
            end
            ST_WAIT_EXEC: exec_start = (cnt_reg == 8'd0);
            ST_BRANCH: begin
                PcSourceControl = SEL_ALUOUT;
                PCWrite = (opcode == 6'h04 && zero) || (opcode == 6'h05 && !zero);
            end
            ST_JUMP: begin
                PcSourceControl = SEL_JTGT;
                PCWrite         = 1'b1;
                link_write      = (opcode == 6'h03);
            end
            ST_JR:  PCWrite = 1'b1;
            ST_RTE: begin
                PcSourceControl = SEL_EPC;
                PCWrite         = 1'b1;
            end
            ST_EXC_SAVE: begin
                alu_pc_minus4 = 1'b1;
                EPCWrite      = 1'b1;
            end
            ST_EXC_VEC: begin
                exc_vec_sel = 1'b1;
                PCWrite     = 1'b1;
            end
            default: ;
        endcase
    end

    assign exc_cause = cause_reg;

endmodule

// File: tb/tb_pc_source_ctrl.sv
// Directed bench for pc_source_ctrl: per-instruction expected cycle sequences checked every cycle.
module tb_pc_source_ctrl;

`ifdef PC_SOURCE_CTRL_OVF_EXC_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h0;
    logic [5:0] funct = 6'h0;
    logic       zero = 1'b0, overflow = 1'b0, illegal_op = 1'b0, exec_done = 1'b0;
    logic [1:0] PcSourceControl, exc_cause;
    logic       PCWrite, IRWrite, EPCWrite, link_write, alu_pc_minus4, exc_vec_sel, exec_start;

    pc_source_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .overflow(overflow), .illegal_op(illegal_op), .exec_done(exec_done),
        .PcSourceControl(PcSourceControl), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .EPCWrite(EPCWrite), .link_write(link_write), .alu_pc_minus4(alu_pc_minus4),
        .exc_vec_sel(exc_vec_sel), .exc_cause(exc_cause), .exec_start(exec_start)
    );

    always #5 clk = ~clk;

    int          checks = 0, failures = 0;
    bit          exp_valid = 1'b0;
    logic [10:0] exp_vec;
    string       tag = "";
    logic [1:0]  m_cause = 2'b00;
    logic [10:0] act_vec;

    assign act_vec = {PcSourceControl, PCWrite, IRWrite, EPCWrite, link_write,
                      alu_pc_minus4, exc_vec_sel, exc_cause, exec_start};

    // Vector layout: sel[1:0] pcw irw epcw link m4 vec cause[1:0] start
    function automatic logic [10:0] ov(input logic [1:0] sel, input logic pcw, irw, epcw,
                                       link, m4, vec, start);
        return {sel, pcw, irw, epcw, link, m4, vec, m_cause, start};
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            if (act_vec !== exp_vec) begin
                failures++;
                $display("FAIL %s t=%0t got=%b expected=%b", tag, $time, act_vec, exp_vec);
            end
        end
    end

    task automatic cyc(input string t, input logic [10:0] e);
        tag       = t;
        exp_vec   = e;
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input string n, input logic [1:0] a, input logic [1:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%b expected=%b", n, a, e);
        end
    endtask

    task automatic take_exc(input logic [1:0] c, input bit rst_in_save);
        exec_done = 1'b0;
        overflow  = 1'b0;
        m_cause   = c;
        if (rst_in_save) reset = 1'b1;
        cyc("exc_save", ov(2'b00, 0, 0, 1, 0, 1, 0, 0));
        if (rst_in_save) begin
            reset   = 1'b0;
            m_cause = 2'b00;
            cyc("rst_after_exc", ov(2'b00, 0, 0, 0, 0, 0, 0, 0));
        end else begin
            cyc("exc_vec", ov(2'b00, 1, 0, 0, 0, 0, 1, 0));
        end
    endtask

    // done_after < 0: exec_done never arrives; otherwise it rises in that WAIT cycle.
    task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input logic ill, input int done_after, input logic ovf,
                         input bit rst_in_save);
        bit finished;
        opcode = op; funct = fn; zero = z; illegal_op = ill;
        exec_done = 1'b0; overflow = 1'b0;
        cyc("fetch", ov(2'b00, 1, 1, 0, 0, 0, 0, 0));
        cyc("decode", ov(2'b00, 0, 0, 0, 0, 0, 0, 0));
        if (ill) begin
            take_exc(2'b00, rst_in_save);
        end else if (op == 6'h02 || op == 6'h03) begin
            cyc("jump", ov(2'b01, 1, 0, 0, op == 6'h03, 0, 0, 0));
        end else if (op == 6'h04 || op == 6'h05) begin
            cyc("branch", ov(2'b10, (op == 6'h04 && z) || (op == 6'h05 && !z), 0, 0, 0, 0, 0, 0));
        end else if (op == 6'h00 && fn == 6'h08) begin
            cyc("jr", ov(2'b00, 1, 0, 0, 0, 0, 0, 0));
        end else if (op == 6'h00 && fn == 6'h13) begin
            cyc("rte", ov(2'b11, 1, 0, 0, 0, 0, 0, 0));
        end else begin
            finished = 1'b0;
            for (int k = 0; k < 255; k++) begin
                exec_done = (k == done_after);
                overflow  = ovf && exec_done;
                cyc("wait_exec", ov(2'b00, 0, 0, 0, 0, 0, 0, k == 0));
                if (k == done_after) begin
                    finished = 1'b1;
                    break;
                end
            end
            exec_done = 1'b0;
            overflow  = 1'b0;
            if (!finished) take_exc(2'b10, rst_in_save);
            else if (ovf && OVF_EN) take_exc(2'b01, rst_in_save);
        end
    endtask

    initial begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset", ov(2'b00, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        cyc("rst_state", ov(2'b00, 0, 0, 0, 0, 0, 0, 0));

        instr(6'h04, 6'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0);   // beq taken
        instr(6'h05, 6'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0);   // bne not taken
        instr(6'h04, 6'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        instr(6'h05, 6'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        instr(6'h03, 6'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0);   // jal
        instr(6'h02, 6'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0);   // j
        instr(6'h00, 6'h08, 1'b0, 1'b0, 0, 1'b0, 1'b0);   // jr
        instr(6'h00, 6'h13, 1'b0, 1'b0, 0, 1'b0, 1'b0);   // rte
        instr(6'h23, 6'h00, 1'b0, 1'b0, 3, 1'b0, 1'b0);   // lw, done after 4 cycles
        instr(6'h00, 6'h20, 1'b0, 1'b0, 0, 1'b0, 1'b0);   // add, done immediately
        instr(6'h23, 6'h00, 1'b0, 1'b0, -1, 1'b0, 1'b0);  // watchdog
        pin("cause_watchdog", exc_cause, 2'b10);
        instr(6'h3f, 6'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0);   // illegal
        pin("cause_illegal", exc_cause, 2'b00);
        instr(6'h04, 6'h00, 1'b1, 1'b1, 0, 1'b0, 1'b0);   // illegal beats branch
        instr(6'h2b, 6'h00, 1'b0, 1'b0, 254, 1'b0, 1'b0); // done on last watchdog cycle
        instr(6'h23, 6'h00, 1'b0, 1'b0, -1, 1'b0, 1'b0);  // cause 10 again
        instr(6'h00, 6'h20, 1'b0, 1'b0, 2, 1'b1, 1'b0);   // overflow with done
        pin("cause_after_ovf", exc_cause, OVF_EN ? 2'b01 : 2'b10);
        instr(6'h23, 6'h00, 1'b0, 1'b0, -1, 1'b0, 1'b1);  // reset during EXC_SAVE
        pin("cause_after_reset", exc_cause, 2'b00);
        instr(6'h03, 6'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        exp_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
